// File: rtl/mips_fetch_pkg.sv
// Shared widths, constants and the fetch-queue payload used by the fetch front end.
package mips_fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned PC_INCR = 4;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction buffer; entry 0 is always the head so the head is a plain register.
module fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     entries [DEPTH];
    logic             pop_ok;
    logic             push_ok;
    logic [IDX_W-1:0] wr_idx;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        pop_ok     = pop && (count != '0);
        push_ok    = push && ((count != CNT_W'(DEPTH)) || pop_ok);
        wr_idx     = pop_ok ? IDX_W'(count - CNT_W'(1)) : IDX_W'(count);
        count_next = flush ? '0 : count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // A pop shifts everything down one slot; a same-cycle push lands behind the shifted tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            empty <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
        end else begin
            count <= count_next;
            empty <= (count_next == '0);
            if (!flush) begin
                if (pop_ok) begin
                    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                        entries[i] <= entries[i+1];
                    end
                end
                if (push_ok) begin
                    entries[wr_idx] <= push_entry;
                end
            end
        end
    end

    assign head = entries[0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues credit-limited pipelined reads and
// hands {instruction, PC} pairs to decode; redirects flush buffered and in-flight work.
module instr_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [PC_W-1:0]  fetch_pc, fetch_pc_next;
    logic [PC_W-1:0]  resp_pc, resp_pc_next;
    logic [CNT_W-1:0] outstanding, outstanding_next;
    logic [CNT_W-1:0] drop, drop_next;
    logic [CNT_W-1:0] q_count, q_count_next;
    logic [SUM_W-1:0] credit_used;
    logic             accept, resp, push, pop, q_empty, mem_req_next;
    fetch_entry_t     push_entry, q_head;
    logic             unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // resp_pc tracks the PC of the next non-dropped response, since fetches are sequential between redirects.
    always_comb begin
        accept           = mem_req && mem_gnt;
        resp             = mem_rvalid && (outstanding != '0);
        push             = resp && (drop == '0) && !redirect;
        pop              = !q_empty && instr_ready;
        push_entry.instr = mem_rdata;
        push_entry.pc    = resp_pc;

        outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(resp);
        fetch_pc_next    = fetch_pc;
        resp_pc_next     = resp_pc;
        drop_next        = drop;
        q_count_next     = q_count + CNT_W'(push) - CNT_W'(pop);

        if (accept) fetch_pc_next = fetch_pc + PC_W'(PC_INCR);
        if (resp && (drop != '0)) drop_next = drop - CNT_W'(1);
        if (push) resp_pc_next = resp_pc + PC_W'(PC_INCR);

        if (redirect) begin
            fetch_pc_next = {redirect_pc[PC_W-1:2], 2'b00};
            resp_pc_next  = {redirect_pc[PC_W-1:2], 2'b00};
            drop_next     = outstanding_next;
            q_count_next  = '0;
        end

        credit_used  = {1'b0, outstanding_next} + {1'b0, q_count_next};
        mem_req_next = credit_used < SUM_W'(DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            mem_req     <= 1'b0;
        end else begin
            fetch_pc    <= fetch_pc_next;
            resp_pc     <= resp_pc_next;
            outstanding <= outstanding_next;
            drop        <= drop_next;
            mem_req     <= mem_req_next;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (q_head),
        .empty      (q_empty),
        .count      (q_count)
    );

    assign mem_addr    = fetch_pc;
    assign instr_valid = !q_empty;
    assign instr       = q_head.instr;
    assign instr_pc    = q_head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: variable-latency memory, queue-based reference model, directed and random phases.
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    int lat_min = 1;
    int lat_max = 1;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; bit stale; } ol_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } iq_t;

    mreq_t       mq[$];
    ol_t         ol[$];
    iq_t         iq[$];
    logic [31:0] m_pc = '0;
    bit          m_req = 1'b0;
    bit          m_acc, m_push;
    iq_t         m_ent;
    ol_t         m_o;
    mreq_t       m_head;

    logic [31:0] acc_obs [16];
    logic [31:0] pop_obs [16];
    int          n_acc, n_pop;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_acc(input string name, input int idx, input logic [31:0] exp);
        if (idx < n_acc) check(name, acc_obs[idx], exp);
        else begin
            n_cmp++; n_bad++;
            $display("FAIL %s: accept #%0d never seen, required %h", name, idx, exp);
        end
    endtask

    task automatic check_pop(input string name, input int idx, input logic [31:0] exp);
        if (idx < n_pop) check(name, pop_obs[idx], exp);
        else begin
            n_cmp++; n_bad++;
            $display("FAIL %s: pop #%0d never seen, required %h", name, idx, exp);
        end
    endtask

    // Records accepted fetch addresses and consumed head PCs for the directed phases.
    task automatic sample();
        if (mem_req && mem_gnt && n_acc < 16) begin acc_obs[n_acc] = mem_addr; n_acc++; end
        if (instr_valid && instr_ready && n_pop < 16) begin pop_obs[n_pop] = instr_pc; n_pop++; end
    endtask

    // Reference model and memory bookkeeping, both advanced on the rising edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            ol.delete(); iq.delete(); mq.delete();
            m_pc  = 32'h0;
            m_req = 1'b0;
        end else begin
            m_acc  = m_req && mem_gnt;
            m_push = 1'b0;
            if (mem_rvalid && ol.size() > 0) begin
                m_o = ol.pop_front();
                if (!m_o.stale && !redirect) begin
                    m_push     = 1'b1;
                    m_ent.data = mem_rdata;
                    m_ent.pc   = m_o.pc;
                end
            end
            if (instr_ready && iq.size() > 0) iq.delete(0);
            if (m_push) iq.push_back(m_ent);
            if (m_acc) begin
                ol.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
            if (redirect) begin
                iq.delete();
                foreach (ol[i]) ol[i].stale = 1'b1;
                m_pc = {redirect_pc[31:2], 2'b00};
            end
            m_req = (ol.size() + iq.size()) < DEPTH;

            if (mem_rvalid && mq.size() > 0) mq.delete(0);
            if (mem_req && mem_gnt)
                mq.push_back('{mem_addr, cyc + int'($urandom_range(lat_max, lat_min)) - 1});
        end
    end

    // Memory responder: in-order, each request returns after its own latency.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (mq.size() > 0) begin
            m_head = mq[0];
            if (m_head.due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = word_at(m_head.addr);
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("mem_req", 32'(mem_req), 32'(m_req));
            if (m_req) check("mem_addr", mem_addr, m_pc);
            check("instr_valid", 32'(instr_valid), 32'(iq.size() != 0));
            if (iq.size() != 0) begin
                check("instr", instr, iq[0].data);
                check("instr_pc", instr_pc, iq[0].pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        int waited;
        int burst;
        bit seen_valid;

        rst_n = 1'b0; mem_gnt = 1'b0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        #1 rst_n = 1'b1; chk_en = 1'b1;

        // Streaming with 1-cycle memory.
        mem_gnt = 1'b1; instr_ready = 1'b1;
        n_acc = 0; n_pop = 0; gaps = 0; seen_valid = 1'b0;
        repeat (16) begin
            sample();
            if (instr_valid) seen_valid = 1'b1;
            else if (seen_valid) gaps++;
            @(negedge clk);
        end
        check_acc("a_acc0", 0, 32'h0); check_acc("a_acc1", 1, 32'h4); check_acc("a_acc2", 2, 32'h8);
        check_pop("a_pop0", 0, 32'h0); check_pop("a_pop1", 1, 32'h4); check_pop("a_pop2", 2, 32'h8);
        check("a_valid_gaps", 32'(gaps), 32'd0);

        // Credit limit with decode stalled.
        mem_gnt = 1'b0;
        repeat (8) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0;
        @(negedge clk);
        redirect = 1'b0; instr_ready = 1'b0; mem_gnt = 1'b1;
        n_acc = 0;
        repeat (15) begin sample(); @(negedge clk); end
        check("b_accepts", 32'(n_acc), 32'd4);
        check("b_mem_req_off", 32'(mem_req), 32'd0);
        instr_ready = 1'b1; n_pop = 0;
        repeat (6) begin sample(); @(negedge clk); end
        check_pop("b_pop0", 0, 32'h0); check_pop("b_pop1", 1, 32'h4);
        check_pop("b_pop2", 2, 32'h8); check_pop("b_pop3", 3, 32'hC);

        // Redirect with 3-cycle memory and fetches in flight.
        lat_min = 3; lat_max = 3;
        repeat (10) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        redirect = 1'b0;
        check("c_addr", mem_addr, 32'h0000_0100);
        check("c_valid_flushed", 32'(instr_valid), 32'd0);
        waited = 0;
        while (!instr_valid && waited < 30) begin @(negedge clk); waited++; end
        if (instr_valid) begin
            check("c_first_pc", instr_pc, 32'h0000_0100);
            check("c_first_instr", instr, word_at(32'h0000_0100));
        end else begin
            n_cmp++; n_bad++;
            $display("FAIL c_first_pc: no valid instruction within 30 cycles, required pc 00000100");
        end

        // Redirect to the top of the address space while accepting and popping.
        lat_min = 1; lat_max = 1;
        repeat (8) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        check("d_valid_flushed", 32'(instr_valid), 32'd0);
        n_acc = 0; n_pop = 0;
        repeat (12) begin sample(); @(negedge clk); end
        check_acc("d_acc0", 0, 32'hFFFF_FFFC); check_acc("d_acc1", 1, 32'h0);
        check_pop("d_pop0", 0, 32'hFFFF_FFFC); check_pop("d_pop1", 1, 32'h0);

        // Random traffic, latencies, stalls and redirect bursts.
        lat_min = 1; lat_max = 4; burst = 0;
        repeat (600) begin
            mem_gnt     = ($urandom_range(3, 0) != 0);
            instr_ready = ($urandom_range(3, 0) != 0);
            if (burst == 0 && $urandom_range(29, 0) == 0) burst = int'($urandom_range(3, 1));
            redirect = (burst > 0);
            if (burst > 0) burst--;
            redirect_pc = $urandom;
            if ($urandom_range(3, 0) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
            @(negedge clk);
        end
        redirect = 1'b0;

        // Asynchronous reset mid-stream, then a late response after release.
        mem_gnt = 1'b1; instr_ready = 1'b1; lat_min = 3; lat_max = 3;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("f_mem_req", 32'(mem_req), 32'd0);
        check("f_mem_addr", mem_addr, 32'h0);
        check("f_instr_valid", 32'(instr_valid), 32'd0);
        check("f_instr", instr, 32'h0);
        check("f_instr_pc", instr_pc, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        n_acc = 0;
        @(negedge clk);
        check("f_late_ignored", 32'(instr_valid), 32'd0);
        repeat (10) begin sample(); @(negedge clk); end
        check_acc("f_acc0", 0, 32'h0); check_acc("f_acc1", 1, 32'h4);
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch front end that sits directly upstream of the core datapath and replaces the direct PC-to-instruction-memory connection. It owns the fetch PC, issues pipelined read requests to an instruction memory with variable latency, and buffers returned words in a small in-order queue. It delivers {instruction, PC} pairs to decode over a valid/ready handshake. Branch and jump redirects from the datapath flush all in-flight and buffered work.

Parameters:
DEPTH, 4, queue entries and maximum outstanding-plus-buffered fetches (power of 2, at least 2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
CLOCK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
MEM_REQ  out  1  fetch request valid
MEM_ADDR  out  32  fetch word address, bits [1:0] always 00
MEM_GNT  in  1  memory accepts request this cycle
MEM_RVALID  in  1  read data valid; responses return in request order
MEM_RDATA  in  32  read data
INSTR_VALID  out  1  queue head valid
INSTR  out  32  queue head instruction
INSTR_PC  out  32  PC of queue head
INSTR_READY  in  1  decode consumes head
REDIRECT  in  1  branch/jump taken, flush
REDIRECT_PC  in  32  new fetch PC; bits [1:0] ignored

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, MEM_REQ=0, MEM_ADDR=RESET_PC, INSTR_VALID=0, INSTR=0, INSTR_PC=0, queue empty, outstanding=0, drop=0.
- MEM_REQ asserts when (outstanding + occupancy) < DEPTH; it first rises in the first cycle after reset release.
- A request is accepted on MEM_REQ && MEM_GNT. On acceptance: outstanding+1, fetch_pc += 4, with modulo-2^32 wrap (32'hFFFF_FFFC becomes 0).
- While MEM_REQ && !MEM_GNT, MEM_ADDR holds stable, except after a redirect.
- MEM_RVALID with drop>0: word discarded, drop-1, outstanding-1.
- MEM_RVALID with drop==0: {MEM_RDATA, pc} pushed to the queue and outstanding-1. The pc value comes from an internal in-order tag FIFO or counter.
- The pushed entry becomes visible on INSTR the next cycle. Minimum latency from acceptance to INSTR_VALID is 2 cycles with 1-cycle memory.
- MEM_RVALID with outstanding==0 is a protocol violation: ignored, no state change.
- Credit rule guarantees the queue never overflows. A push and a pop in the same cycle are both performed.
- INSTR_VALID = queue not empty. The head pops on INSTR_VALID && INSTR_READY. INSTR/INSTR_PC are held stable while valid and not ready.
- REDIRECT (highest priority), applied at the clock edge:
  - queue flushed, so INSTR_VALID=0 next cycle;
  - fetch_pc = {REDIRECT_PC[31:2], 2'b00};
  - drop = outstanding after this cycle's accept and response are counted;
  - a request accepted in the redirect cycle is therefore stale;
  - a pop in the redirect cycle is still a valid consume;
  - a response arriving in the redirect cycle is discarded.
- Requests for the new PC may issue the cycle after a redirect, subject to credit. Stale responses do not consume queue space.
- Back-to-back redirects: each one recomputes drop and the last one wins fetch_pc.
- RESET_N asserted mid-operation: all state cleared immediately. Responses arriving after release are treated as the protocol violation above.

Decomposition:
- Shared package mips_fetch_pkg holds: INSTR_W=32, PC_W=32, PC_INCR=4, the default RESET_PC constant, and the count width function clog2(DEPTH+1).
- One sub-module, fetch_queue: synchronous FIFO of DEPTH x 64 bits with push, pop, flush, empty/count outputs, and an active-low async reset.
- The top holds the PC, credit, drop and tag logic.

Test Plan:
- Reset release, 1-cycle memory with MEM_GNT=1, INSTR_READY=1 -> MEM_ADDR sequence 0,4,8,...; INSTR_PC 0,4,8 in order; INSTR_VALID sustained high.
- INSTR_READY=0, DEPTH=4 -> exactly 4 accepts, then MEM_REQ=0; after READY returns, heads drain 0,4,8,12 unchanged.
- Memory latency 3 cycles, REDIRECT to 32'h0000_0103 with 2 outstanding -> both stale words dropped; next MEM_ADDR=32'h0000_0100; first INSTR_PC=32'h100.
- REDIRECT in the same cycle as an accept and a pop -> the accepted fetch is dropped, the popped instruction counts as consumed, INSTR_VALID=0 next cycle.
- REDIRECT_PC=32'hFFFF_FFFC -> fetch addresses FFFF_FFFC, then 0000_0000, with INSTR_PC matching.
- RESET_N pulsed low mid-stream with 2 outstanding -> outputs return to reset values asynchronously; restart fetches RESET_PC; late MEM_RVALID is ignored.
